// File: rtl/simple_cpu_mc.sv
// rtl/simple_cpu_mc.sv - multicycle 4-op CPU with valid/ready instruction intake and debug read ports
// Optional: define CPU_MUL_EN to make ALU funct 5 a truncating multiply.
module simple_cpu_mc #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20,
  parameter int REG_BITS    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   done,
  output logic                   illegal,
  input  logic [REG_BITS-1:0]    dbg_reg_sel,
  output logic [DATA_WIDTH-1:0]  dbg_reg_data,
  input  logic [ADDR_BITS-1:0]   dbg_mem_addr,
  output logic [DATA_WIDTH-1:0]  dbg_mem_data
);
  localparam int NUM_REGS  = 2**REG_BITS;
  localparam int MEM_DEPTH = 2**ADDR_BITS;

  localparam logic [1:0] OP_ADDI  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b11;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  state_t                  state;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   mem  [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   rx1, rx2, rx3, res;
  logic [ADDR_BITS-1:0]    maddr;
  logic                    bad;

  logic [1:0]              op;
  logic [REG_BITS-1:0]     x1, x2, x3;
  logic [7:0]              imm;
  logic [3:0]              funct;

  assign op    = ir[INSTR_WIDTH-1 -: 2];
  assign x1    = ir[INSTR_WIDTH-3 -: REG_BITS];
  assign x2    = ir[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
  assign x3    = ir[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];
  assign imm   = ir[INSTR_WIDTH-3-3*REG_BITS -: 8];
  assign funct = ir[3:0];

  assign instr_ready  = (state == IDLE);
  assign dbg_reg_data = regs[dbg_reg_sel];
  assign dbg_mem_data = mem[dbg_mem_addr];

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_bad;
  logic [ADDR_BITS-1:0]  addr_calc;

  // Truncating both terms before the add gives the same wrapped address as a full-width sum.
  assign addr_calc = ADDR_BITS'(rx2) + ADDR_BITS'(imm);

  always_comb begin
    alu_res = '0;
    alu_bad = 1'b0;
    if (op == OP_ADDI) begin
      alu_res = rx2 + DATA_WIDTH'(imm);
    end else begin
      case (funct)
        4'd0: alu_res = rx2 + rx3;
        4'd1: alu_res = rx2 - rx3;
        4'd2: alu_res = rx2 & rx3;
        4'd3: alu_res = rx2 | rx3;
        4'd4: alu_res = rx2 ^ rx3;
`ifdef CPU_MUL_EN
        4'd5: alu_res = rx2 * rx3;
`endif
        default: alu_bad = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ir      <= '0;
      rx1     <= '0;
      rx2     <= '0;
      rx3     <= '0;
      res     <= '0;
      maddr   <= '0;
      bad     <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_WIDTH'(i);
      for (int j = 0; j < MEM_DEPTH; j++) mem[j] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instruction;
            state <= DECODE;
          end
        end
        DECODE: begin
          rx1   <= regs[x1];
          rx2   <= regs[x2];
          rx3   <= regs[x3];
          state <= EXEC;
        end
        EXEC: begin
          if (op[1]) begin
            maddr <= addr_calc;
            state <= MEM;
          end else begin
            res   <= alu_res;
            bad   <= (op == OP_ALU) && alu_bad;
            state <= WB;
          end
        end
        MEM: begin
          if (op == OP_STORE) begin
            mem[maddr] <= rx1;
            done       <= 1'b1;
            state      <= IDLE;
          end else begin
            res   <= mem[maddr];
            bad   <= 1'b0;
            state <= WB;
          end
        end
        WB: begin
          if (!bad) regs[x1] <= res;
          done    <= 1'b1;
          illegal <= bad;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/simple_cpu_mc.md
Name: simple_cpu_mc

Overview:
Parametrised multicycle successor to the single-cycle simple CPU. It keeps the same 20-bit instruction format but adds a configurable register count, a valid/ready instruction handshake and an explicit FSM. The ALU gains ADDI and logic ops, and the block provides a register/memory debug read port for verification. It sits between an external instruction source (bench or fetch unit) and an internal register file and data memory.

Parameters:
DATA_WIDTH, 8, register and memory word width
ADDR_BITS, 5, data-memory address width (depth 2**ADDR_BITS)
INSTR_WIDTH, 20, instruction width; must be >= 2+3*REG_BITS+4+8
REG_BITS, 2, register index width (NUM_REGS = 2**REG_BITS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
instruction  in  INSTR_WIDTH  instruction word
instr_valid  in  1  instruction present
instr_ready  out  1  CPU can accept; high only in IDLE
done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse with done for an undefined funct
dbg_reg_sel  in  REG_BITS  debug register index
dbg_reg_data  out  DATA_WIDTH  regfile[dbg_reg_sel], combinational
dbg_mem_addr  in  ADDR_BITS  debug memory address
dbg_mem_data  out  DATA_WIDTH  mem[dbg_mem_addr], combinational

Behaviour:
- Fields, MSB first: op[IW-1:IW-2], X1, X2, X3 (REG_BITS each), imm = next 8 bits down to bit 4, funct[3:0]. Default layout: X1[17:16], X2[15:14], X3[13:12], imm[11:4].
- op 00 ADDI: X1 = X2 + imm.
- op 01 ALU: X1 = X2 op X3. funct 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; any other funct is illegal.
- op 10 LOAD_R: X1 = mem[X2+imm].
- op 11 STORE_R: mem[X2+imm] = X1.
- Arithmetic is modulo 2**DATA_WIDTH; carry and borrow are discarded.
- Memory address = (reg[X2] + imm) mod 2**ADDR_BITS, so the address wraps.
- imm is zero-extended, or truncated to DATA_WIDTH where needed.
- Reset (rst=0, asynchronous): regfile[i] = i truncated to DATA_WIDTH; all memory words = 0; state = IDLE; done = 0, illegal = 0; instr_ready = 1 once rst is released.
- Handshake: accept on a rising edge with instr_valid && instr_ready. The instruction is latched at accept; later changes on the input are ignored until the next accept. instr_ready is 0 in every state except IDLE.
- FSM states: IDLE, DECODE, EXEC, MEM, WB.
- IDLE -> DECODE on accept (edge E0).
- DECODE -> EXEC (E1): reg[X1], reg[X2], reg[X3] latched.
- EXEC (E2): ALU/ADDI result, or memory address, latched. Next state is WB for ALU/ADDI and MEM for LOAD/STORE.
- MEM (E3): STORE writes memory and goes to IDLE. LOAD latches mem data and goes to WB.
- WB: regfile written on the leaving edge; next state IDLE.
- Latency from accept edge to architectural update: ALU/ADDI at E3, STORE at E3, LOAD at E4.
- done is high for the cycle after the update edge; instr_ready rises in that same cycle.
- Back-to-back: an instruction accepted in the done cycle sees the updated registers.
- Illegal funct: no register write; done and illegal pulse at the normal ALU timing.
- X1 may equal X2 or X3; operands were latched in DECODE, so the result uses the old values.
- Reset mid-instruction: aborts with no partial write; all state returns to reset values.

Optional Feature:
CPU_MUL_EN
- Defined: funct 5 = MUL, keeping the low DATA_WIDTH bits of X2*X3, with ALU timing.
- Undefined: funct 5 is illegal. No multiplier is synthesised.

Test Plan:
- Reset then release -> regs 0,1,2,3; mem[0..31] = 0; instr_ready = 1; done = 0.
- ADD r0=r1+r3 -> r0 = 4 at E3, done at E3+1. Then SUB r3=r0-r2 -> r3 = 2. Then SUB r2=r1-r3 -> r2 = 0xFF (wrap). Then ADDI r1=r1+200 -> r1 = 201.
- STORE r1 to [r2+15] with r1=1, r2=2 -> mem[17] = 1. LOAD r3 from [r2+15] -> r3 = 1 at E4. STORE r0 to [r3+31] with r3=3 -> mem[2] = 0 (address wraps to 2).
- instr_valid held with a second ADD during the first ADD -> instr_ready = 0, second accepted only when the first's done is high. Instruction changed mid-op -> first result unaffected.
- rst pulled low in EXEC of ADD r0=r1+r3 -> r0 remains 0, state IDLE, no done pulse.
- funct 7 -> registers unchanged, done = 1 and illegal = 1 for one cycle.
- With CPU_MUL_EN: funct 5 r0=r2*r3 -> 6; operands 0x10*0x10 -> 0x00.
- Without CPU_MUL_EN: funct 5 -> illegal pulse, no register write.
